// File: rtl/local_pht_if.sv
// local_pht_if: lookup / commit / prediction bundle for the local pattern
// history table.
//   master : fetch/commit side (drives lookup and commit, sees prediction)
//   slave  : the table itself
// Signals:
//   lpht_rd_valid_i / lpht_rd_index_i                  lookup request + BHT history
//   lpht_cm_valid_i / lpht_cm_index_i / lpht_cm_brdir_i commit update
//   lpht_ready_o                                       table initialised
//   lpht_pred_valid_o / lpht_pred_taken_o / lpht_pred_cnt_o  registered prediction
interface local_pht_if #(
  parameter int IDX_W = 10,
  parameter int CNT_W = 3
);
  logic             lpht_rd_valid_i;
  logic [IDX_W-1:0] lpht_rd_index_i;
  logic             lpht_cm_valid_i;
  logic [IDX_W-1:0] lpht_cm_index_i;
  logic             lpht_cm_brdir_i;
  logic             lpht_ready_o;
  logic             lpht_pred_valid_o;
  logic             lpht_pred_taken_o;
  logic [CNT_W-1:0] lpht_pred_cnt_o;

  modport master (
    output lpht_rd_valid_i, lpht_rd_index_i,
    output lpht_cm_valid_i, lpht_cm_index_i, lpht_cm_brdir_i,
    input  lpht_ready_o, lpht_pred_valid_o, lpht_pred_taken_o, lpht_pred_cnt_o
  );

  modport slave (
    input  lpht_rd_valid_i, lpht_rd_index_i,
    input  lpht_cm_valid_i, lpht_cm_index_i, lpht_cm_brdir_i,
    output lpht_ready_o, lpht_pred_valid_o, lpht_pred_taken_o, lpht_pred_cnt_o
  );
endinterface

// File: rtl/local_pht.sv
// local_pht: local pattern history table. 2**IDX_W saturating counters of
// CNT_W bits, indexed by local branch history. One lookup and one commit
// update per cycle; the prediction is registered (1-cycle latency).
// After reset an internal sequencer writes INIT_VAL to every entry, so the
// array itself carries no reset.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high
//   lpht   local_pht_if.slave (lookup, commit, ready, prediction)
module local_pht #(
  parameter int IDX_W    = 10,
  parameter int CNT_W    = 3,
  parameter int INIT_VAL = 3
) (
  input  logic        clock,
  input  logic        reset,
  local_pht_if.slave  lpht
);
  localparam int              DEPTH    = 2**IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(INIT_VAL);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [CNT_W-1:0] mem [DEPTH];

  logic             we;
  logic [IDX_W-1:0] waddr;
  logic [CNT_W-1:0] wdata;
  logic [CNT_W-1:0] cm_cur, cm_next;
  logic             run, bypass;

  logic             vld_pipe;
  logic [CNT_W-1:0] cnt_q;

  assign run = (state_q == S_RUN);

  // Saturation is tested on the old value so the counter never wraps.
  assign cm_cur = mem[lpht.lpht_cm_index_i];
  always_comb begin
    cm_next = cm_cur;
    if (lpht.lpht_cm_brdir_i) begin
      if (cm_cur != CNT_MAX) cm_next = cm_cur + 1'b1;
    end else begin
      if (cm_cur != '0) cm_next = cm_cur - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Single write port: owned by the init sweep in INIT, by commits in RUN.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we      = 1'b0;
    waddr   = lpht.lpht_cm_index_i;
    wdata   = cm_next;
    case (state_q)
      S_INIT: begin
        we    = 1'b1;
        waddr = ptr_q;
        wdata = INIT_CNT;
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1) state_d = S_RUN;
      end
      S_RUN: begin
        we = lpht.lpht_cm_valid_i;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-index commit and lookup: forward the updated count so the
  // prediction never sees the stale array value.
  assign bypass = lpht.lpht_cm_valid_i &&
                  (lpht.lpht_cm_index_i == lpht.lpht_rd_index_i);

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= 1'b0;
      cnt_q    <= '0;
    end else begin
      vld_pipe <= run && lpht.lpht_rd_valid_i;
      if (run && lpht.lpht_rd_valid_i)
        cnt_q <= bypass ? cm_next : mem[lpht.lpht_rd_index_i];
    end
  end

  assign lpht.lpht_ready_o      = run;
  assign lpht.lpht_pred_valid_o = vld_pipe;
  assign lpht.lpht_pred_cnt_o   = cnt_q;
  assign lpht.lpht_pred_taken_o = cnt_q[CNT_W-1];
endmodule
